pc_src_ctrl: RTL and testbench

- Next-PC source controller: computes the 3-bit `PC_src_sel` for the fetch PC register every cycle.
- Resolves redirects from the DX stage, fetch replays, and trap entry/exit.
- Owns `epc`, the trap cause and the pipeline flush strobes.
- Sits between the hazard/execute logic and the PC register. Its `epc` output drives the PC register's `epc` input directly.

---
 rtl/pc_ctrl_pkg.sv | 31 +++
 rtl/pc_src_ctrl.sv | 183 ++++++++++++++++++
 tb/tb_pc_src_ctrl.sv | 307 ++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/pc_ctrl_pkg.sv
// Shared encodings for the next-PC source selection path.
// The PC register and the controller both import this package.
package pc_ctrl_pkg;

  // Next-PC source select driven to the PC register.
  // Encoding 6 is reserved and never driven.
  typedef enum logic [2:0] {
    PC_SRC_JAL     = 3'd0,
    PC_SRC_JALR    = 3'd1,
    PC_SRC_BRANCH  = 3'd2,
    PC_SRC_REPLAY  = 3'd3,
    PC_SRC_HANDLER = 3'd4,
    PC_SRC_EP      = 3'd5,
    PC_SRC_SEQ     = 3'd7
  } pc_src_e;

  // Trap controller states.
  typedef enum logic [1:0] {
    ST_RUN        = 2'd0,
    ST_TRAP_DRAIN = 2'd1,
    ST_HANDLER    = 2'd2
  } pc_state_e;

  // Default cause codes.
  localparam logic [3:0] CAUSE_IRQ_DEF = 4'hB;
  localparam logic [3:0] CAUSE_ILL_DEF = 4'h2;

  // Drain counter width; large enough for DRAIN_CYCLES up to 15.
  localparam int unsigned DRAIN_CNT_W = 4;

endpackage

// File: rtl/pc_src_ctrl.sv
// Next-PC source controller: picks the PC register source every cycle,
// resolves DX redirects, fetch replays and trap entry/exit, and owns
// epc, cause and the pipeline flush strobes.
module pc_src_ctrl
  import pc_ctrl_pkg::*;
#(
  parameter int unsigned          DRAIN_CYCLES = 2,
  parameter int unsigned          CAUSE_W      = 4,
  parameter logic [CAUSE_W-1:0]   IRQ_CAUSE    = CAUSE_W'(CAUSE_IRQ_DEF),
  parameter logic [CAUSE_W-1:0]   ILL_CAUSE    = CAUSE_W'(CAUSE_ILL_DEF)
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               dx_valid,
  input  logic [31:0]        pc_dx,
  input  logic               jal_dx,
  input  logic               jalr_dx,
  input  logic               br_taken_dx,
  input  logic               mret_dx,
  input  logic               exc_req,
  input  logic [CAUSE_W-1:0] exc_cause,
  input  logic               irq_req,
  input  logic               irq_en,
  input  logic               fetch_stall,
  output logic [2:0]         pc_src_sel,
  output logic               flush_if,
  output logic               flush_dx,
  output logic [31:0]        epc,
  output logic [CAUSE_W-1:0] cause,
  output logic               in_handler,
  output logic               double_fault
);

  localparam logic [DRAIN_CNT_W-1:0] DRAIN_LOAD = DRAIN_CNT_W'(DRAIN_CYCLES - 1);

  pc_state_e                state_q;
  logic [31:0]              epc_q;
  logic [CAUSE_W-1:0]       cause_q;
  logic                     dbl_q;
  logic [DRAIN_CNT_W-1:0]   cnt_q;

  // DX events only count when the DX slot holds a valid instruction.
  logic exc_v, mret_v, jal_v, jalr_v, br_v, xfer_v;
  assign exc_v  = dx_valid & exc_req;
  assign mret_v = dx_valid & mret_dx;
  assign jal_v  = dx_valid & jal_dx;
  assign jalr_v = dx_valid & jalr_dx;
  assign br_v   = dx_valid & br_taken_dx;
  assign xfer_v = jal_v | jalr_v | br_v;

  pc_src_e redir_sel;
  logic    redir_fif;

  // Non-trap source selection shared by RUN and HANDLER.
  always_comb begin
    redir_sel = PC_SRC_SEQ;
    redir_fif = 1'b0;
    if (jalr_v) begin
      redir_sel = PC_SRC_JALR;
      redir_fif = 1'b1;
    end else if (jal_v) begin
      redir_sel = PC_SRC_JAL;
      redir_fif = 1'b1;
    end else if (br_v) begin
      redir_sel = PC_SRC_BRANCH;
      redir_fif = 1'b1;
    end else if (fetch_stall) begin
      redir_sel = PC_SRC_REPLAY;
    end
  end

  pc_src_e            sel_c;
  logic               fif_c;
  logic               fdx_c;
  logic               trap_go;
  logic [CAUSE_W-1:0] trap_cause;
  logic               dbl_go;
  logic               ret_go;

  // Per-state decision: combinational outputs plus the transition requests
  // consumed by the state register. Held at SEQ/no-flush while in reset.
  always_comb begin
    sel_c      = PC_SRC_SEQ;
    fif_c      = 1'b0;
    fdx_c      = 1'b0;
    trap_go    = 1'b0;
    trap_cause = exc_cause;
    dbl_go     = 1'b0;
    ret_go     = 1'b0;
    if (rst_n) begin
      unique case (state_q)
        ST_RUN: begin
          if (exc_v || mret_v || (irq_req && irq_en && !xfer_v)) begin
            sel_c   = PC_SRC_HANDLER;
            fif_c   = 1'b1;
            fdx_c   = 1'b1;
            trap_go = 1'b1;
            if (exc_v)       trap_cause = exc_cause;
            else if (mret_v) trap_cause = ILL_CAUSE;
            else             trap_cause = IRQ_CAUSE;
          end else begin
            sel_c = redir_sel;
            fif_c = redir_fif;
          end
        end
        ST_TRAP_DRAIN: begin
          fdx_c = 1'b1;
          sel_c = fetch_stall ? PC_SRC_REPLAY : PC_SRC_SEQ;
        end
        ST_HANDLER: begin
          if (exc_v) begin
            sel_c  = PC_SRC_HANDLER;
            fif_c  = 1'b1;
            fdx_c  = 1'b1;
            dbl_go = 1'b1;
          end else if (mret_v) begin
            sel_c  = PC_SRC_EP;
            fif_c  = 1'b1;
            fdx_c  = 1'b1;
            ret_go = 1'b1;
          end else begin
            sel_c = redir_sel;
            fif_c = redir_fif;
          end
        end
        default: begin
          sel_c = PC_SRC_SEQ;
        end
      endcase
    end
  end

  // State, trap context, sticky double-fault flag and drain counter.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_RUN;
      epc_q   <= '0;
      cause_q <= '0;
      dbl_q   <= 1'b0;
      cnt_q   <= '0;
    end else begin
      unique case (state_q)
        ST_RUN: begin
          if (trap_go) begin
            epc_q   <= pc_dx;
            cause_q <= trap_cause;
            cnt_q   <= DRAIN_LOAD;
            state_q <= ST_TRAP_DRAIN;
          end
        end
        ST_TRAP_DRAIN: begin
          if (cnt_q == '0) begin
            state_q <= ST_HANDLER;
          end else begin
            cnt_q <= cnt_q - 1'b1;
          end
        end
        ST_HANDLER: begin
          // A nested exception keeps the original epc/cause for diagnosis.
          if (dbl_go) begin
            dbl_q   <= 1'b1;
            cnt_q   <= DRAIN_LOAD;
            state_q <= ST_TRAP_DRAIN;
          end else if (ret_go) begin
            state_q <= ST_RUN;
          end
        end
        default: begin
          state_q <= ST_RUN;
        end
      endcase
    end
  end

  assign pc_src_sel   = sel_c;
  assign flush_if     = fif_c;
  assign flush_dx     = fdx_c;
  assign epc          = epc_q;
  assign cause        = cause_q;
  assign double_fault = dbl_q;
  assign in_handler   = (state_q == ST_TRAP_DRAIN) || (state_q == ST_HANDLER);

endmodule

// File: tb/tb_pc_src_ctrl.sv
// Self-checking bench for pc_src_ctrl (DRAIN_CYCLES=2).
module tb_pc_src_ctrl;

  logic        clk;
  logic        rst_n;
  logic        dx_valid;
  logic [31:0] pc_dx;
  logic        jal_dx, jalr_dx, br_taken_dx, mret_dx, exc_req;
  logic [3:0]  exc_cause;
  logic        irq_req, irq_en, fetch_stall;
  logic [2:0]  pc_src_sel;
  logic        flush_if, flush_dx;
  logic [31:0] epc;
  logic [3:0]  cause;
  logic        in_handler, double_fault;

  pc_src_ctrl #(
    .DRAIN_CYCLES (2),
    .CAUSE_W      (4),
    .IRQ_CAUSE    (4'hB),
    .ILL_CAUSE    (4'h2)
  ) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .dx_valid     (dx_valid),
    .pc_dx        (pc_dx),
    .jal_dx       (jal_dx),
    .jalr_dx      (jalr_dx),
    .br_taken_dx  (br_taken_dx),
    .mret_dx      (mret_dx),
    .exc_req      (exc_req),
    .exc_cause    (exc_cause),
    .irq_req      (irq_req),
    .irq_en       (irq_en),
    .fetch_stall  (fetch_stall),
    .pc_src_sel   (pc_src_sel),
    .flush_if     (flush_if),
    .flush_dx     (flush_dx),
    .epc          (epc),
    .cause        (cause),
    .in_handler   (in_handler),
    .double_fault (double_fault)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Event bit order: {jal, jalr, br, mret, exc}
  localparam logic [4:0] EV_NONE = 5'b00000;
  localparam logic [4:0] EV_JAL  = 5'b10000;
  localparam logic [4:0] EV_JALR = 5'b01000;
  localparam logic [4:0] EV_BR   = 5'b00100;
  localparam logic [4:0] EV_MRET = 5'b00010;
  localparam logic [4:0] EV_EXC  = 5'b00001;

  typedef struct packed {
    logic        dxv;
    logic [31:0] pc;
    logic [4:0]  ev;
    logic [3:0]  ec;
    logic        irq;
    logic        ien;
    logic        stall;
  } stim_t;

  typedef struct packed {
    logic [2:0]  sel;
    logic        fif;
    logic        fdx;
    logic        inh;
    logic        dbl;
    logic [3:0]  cause;
    logic [31:0] epc;
  } snap_t;

  typedef struct {
    stim_t s;
    snap_t e;
  } row_t;

  snap_t sb[$];
  int    checks   = 0;
  int    failures = 0;

  function automatic stim_t S(logic dxv, logic [31:0] pc, logic [4:0] ev, logic [3:0] ec,
                              logic irq, logic ien, logic stall);
    stim_t s;
    s.dxv = dxv; s.pc = pc; s.ev = ev; s.ec = ec;
    s.irq = irq; s.ien = ien; s.stall = stall;
    return s;
  endfunction

  function automatic snap_t E(logic [2:0] sel, logic fif, logic fdx, logic inh, logic dbl,
                              logic [3:0] c, logic [31:0] e);
    snap_t x;
    x.sel = sel; x.fif = fif; x.fdx = fdx; x.inh = inh; x.dbl = dbl;
    x.cause = c; x.epc = e;
    return x;
  endfunction

  function automatic snap_t sample();
    return E(pc_src_sel, flush_if, flush_dx, in_handler, double_fault, cause, epc);
  endfunction

  function automatic string fmt(snap_t x);
    return $sformatf("sel=%0d fif=%b fdx=%b inh=%b dbl=%b cause=%h epc=%h",
                     x.sel, x.fif, x.fdx, x.inh, x.dbl, x.cause, x.epc);
  endfunction

  task automatic apply(stim_t s);
    dx_valid    = s.dxv;
    pc_dx       = s.pc;
    {jal_dx, jalr_dx, br_taken_dx, mret_dx, exc_req} = s.ev;
    exc_cause   = s.ec;
    irq_req     = s.irq;
    irq_en      = s.ien;
    fetch_stall = s.stall;
  endtask

  task automatic test_reset();
    snap_t exp_v, obs;
    rst_n = 1'b0;
    // Events during reset must not leak to the outputs.
    apply(S(1, 32'h10, EV_EXC | EV_JAL, 4'h5, 1, 1, 1));
    sb.push_back(E(3'd7, 0, 0, 0, 0, 4'h0, 32'h0));
    @(negedge clk);
    exp_v = sb.pop_front(); obs = sample(); checks++;
    if (obs !== exp_v) begin
      failures++; $display("FAIL reset_hold got %s want %s", fmt(obs), fmt(exp_v));
    end
    @(posedge clk); #1;
    rst_n = 1'b1;
    apply(S(0, 32'h0, EV_NONE, 4'h0, 0, 0, 0));
    sb.push_back(E(3'd7, 0, 0, 0, 0, 4'h0, 32'h0));
    @(negedge clk);
    exp_v = sb.pop_front(); obs = sample(); checks++;
    if (obs !== exp_v) begin
      failures++; $display("FAIL reset_release got %s want %s", fmt(obs), fmt(exp_v));
    end
  endtask

  task automatic test_redirect_priority();
    row_t  rows[$];
    snap_t exp_v, obs;
    rows.push_back('{S(1, 32'h40, EV_JALR | EV_BR, 4'h0, 0, 0, 1), E(3'd1, 1, 0, 0, 0, 4'h0, 32'h0)});
    rows.push_back('{S(0, 32'h40, EV_NONE, 4'h0, 0, 0, 1),        E(3'd3, 0, 0, 0, 0, 4'h0, 32'h0)});
    rows.push_back('{S(1, 32'h44, EV_JAL, 4'h0, 0, 0, 0),         E(3'd0, 1, 0, 0, 0, 4'h0, 32'h0)});
    rows.push_back('{S(1, 32'h48, EV_BR, 4'h0, 0, 0, 1),          E(3'd2, 1, 0, 0, 0, 4'h0, 32'h0)});
    rows.push_back('{S(1, 32'h4C, EV_JAL | EV_JALR, 4'h0, 0, 0, 0), E(3'd1, 1, 0, 0, 0, 4'h0, 32'h0)});
    rows.push_back('{S(0, 32'h50, EV_JAL | EV_EXC | EV_MRET, 4'h5, 0, 0, 0), E(3'd7, 0, 0, 0, 0, 4'h0, 32'h0)});
    rows.push_back('{S(1, 32'h54, EV_NONE, 4'h0, 1, 0, 0),        E(3'd7, 0, 0, 0, 0, 4'h0, 32'h0)});
    foreach (rows[i]) begin
      @(posedge clk); #1;
      apply(rows[i].s);
      sb.push_back(rows[i].e);
      @(negedge clk);
      exp_v = sb.pop_front(); obs = sample(); checks++;
      if (obs !== exp_v) begin
        failures++; $display("FAIL redirect[%0d] got %s want %s", i, fmt(obs), fmt(exp_v));
      end
    end
  endtask

  task automatic test_exception_entry();
    row_t  rows[$];
    snap_t exp_v, obs;
    rows.push_back('{S(1, 32'h100, EV_EXC, 4'h5, 0, 0, 0),          E(3'd4, 1, 1, 0, 0, 4'h0, 32'h0)});
    rows.push_back('{S(0, 32'h0, EV_NONE, 4'h0, 0, 0, 1),           E(3'd3, 0, 1, 1, 0, 4'h5, 32'h100)});
    rows.push_back('{S(1, 32'h104, EV_EXC | EV_JAL, 4'h9, 1, 1, 0), E(3'd7, 0, 1, 1, 0, 4'h5, 32'h100)});
    rows.push_back('{S(0, 32'h0, EV_NONE, 4'h0, 0, 0, 0),           E(3'd7, 0, 0, 1, 0, 4'h5, 32'h100)});
    rows.push_back('{S(1, 32'h108, EV_NONE, 4'h0, 1, 1, 0),         E(3'd7, 0, 0, 1, 0, 4'h5, 32'h100)});
    rows.push_back('{S(1, 32'h10C, EV_BR, 4'h0, 0, 0, 0),           E(3'd2, 1, 0, 1, 0, 4'h5, 32'h100)});
    foreach (rows[i]) begin
      @(posedge clk); #1;
      apply(rows[i].s);
      sb.push_back(rows[i].e);
      @(negedge clk);
      exp_v = sb.pop_front(); obs = sample(); checks++;
      if (obs !== exp_v) begin
        failures++; $display("FAIL exception[%0d] got %s want %s", i, fmt(obs), fmt(exp_v));
      end
    end
  endtask

  task automatic test_double_fault();
    row_t  rows[$];
    snap_t exp_v, obs;
    rows.push_back('{S(1, 32'h300, EV_EXC, 4'h7, 0, 0, 0), E(3'd4, 1, 1, 1, 0, 4'h5, 32'h100)});
    rows.push_back('{S(0, 32'h0, EV_NONE, 4'h0, 0, 0, 0),  E(3'd7, 0, 1, 1, 1, 4'h5, 32'h100)});
    rows.push_back('{S(0, 32'h0, EV_NONE, 4'h0, 0, 0, 0),  E(3'd7, 0, 1, 1, 1, 4'h5, 32'h100)});
    rows.push_back('{S(0, 32'h0, EV_NONE, 4'h0, 0, 0, 0),  E(3'd7, 0, 0, 1, 1, 4'h5, 32'h100)});
    foreach (rows[i]) begin
      @(posedge clk); #1;
      apply(rows[i].s);
      sb.push_back(rows[i].e);
      @(negedge clk);
      exp_v = sb.pop_front(); obs = sample(); checks++;
      if (obs !== exp_v) begin
        failures++; $display("FAIL double_fault[%0d] got %s want %s", i, fmt(obs), fmt(exp_v));
      end
    end
  endtask

  task automatic test_return();
    row_t  rows[$];
    snap_t exp_v, obs;
    rows.push_back('{S(1, 32'h110, EV_MRET, 4'h0, 0, 0, 1), E(3'd5, 1, 1, 1, 1, 4'h5, 32'h100)});
    rows.push_back('{S(0, 32'h0, EV_NONE, 4'h0, 0, 0, 0),   E(3'd7, 0, 0, 0, 1, 4'h5, 32'h100)});
    foreach (rows[i]) begin
      @(posedge clk); #1;
      apply(rows[i].s);
      sb.push_back(rows[i].e);
      @(negedge clk);
      exp_v = sb.pop_front(); obs = sample(); checks++;
      if (obs !== exp_v) begin
        failures++; $display("FAIL return[%0d] got %s want %s", i, fmt(obs), fmt(exp_v));
      end
    end
  endtask

  task automatic test_irq_deferral();
    row_t  rows[$];
    snap_t exp_v, obs;
    rows.push_back('{S(1, 32'h1F0, EV_BR, 4'h0, 1, 1, 0),   E(3'd2, 1, 0, 0, 1, 4'h5, 32'h100)});
    rows.push_back('{S(1, 32'h200, EV_NONE, 4'h0, 1, 1, 0), E(3'd4, 1, 1, 0, 1, 4'h5, 32'h100)});
    rows.push_back('{S(0, 32'h0, EV_NONE, 4'h0, 1, 1, 0),   E(3'd7, 0, 1, 1, 1, 4'hB, 32'h200)});
    rows.push_back('{S(0, 32'h0, EV_NONE, 4'h0, 1, 1, 0),   E(3'd7, 0, 1, 1, 1, 4'hB, 32'h200)});
    rows.push_back('{S(0, 32'h0, EV_NONE, 4'h0, 1, 1, 0),   E(3'd7, 0, 0, 1, 1, 4'hB, 32'h200)});
    rows.push_back('{S(1, 32'h210, EV_MRET, 4'h0, 0, 0, 0), E(3'd5, 1, 1, 1, 1, 4'hB, 32'h200)});
    rows.push_back('{S(1, 32'h214, EV_NONE, 4'h0, 1, 0, 0), E(3'd7, 0, 0, 0, 1, 4'hB, 32'h200)});
    foreach (rows[i]) begin
      @(posedge clk); #1;
      apply(rows[i].s);
      sb.push_back(rows[i].e);
      @(negedge clk);
      exp_v = sb.pop_front(); obs = sample(); checks++;
      if (obs !== exp_v) begin
        failures++; $display("FAIL irq[%0d] got %s want %s", i, fmt(obs), fmt(exp_v));
      end
    end
  endtask

  task automatic test_mret_in_run();
    row_t  rows[$];
    snap_t exp_v, obs;
    rows.push_back('{S(1, 32'h400, EV_MRET, 4'h0, 0, 0, 0),          E(3'd4, 1, 1, 0, 1, 4'hB, 32'h200)});
    rows.push_back('{S(0, 32'h0, EV_NONE, 4'h0, 0, 0, 0),            E(3'd7, 0, 1, 1, 1, 4'h2, 32'h400)});
    rows.push_back('{S(0, 32'h0, EV_NONE, 4'h0, 0, 0, 0),            E(3'd7, 0, 1, 1, 1, 4'h2, 32'h400)});
    rows.push_back('{S(0, 32'h0, EV_NONE, 4'h0, 0, 0, 0),            E(3'd7, 0, 0, 1, 1, 4'h2, 32'h400)});
    rows.push_back('{S(1, 32'h500, EV_MRET | EV_EXC, 4'h3, 0, 0, 0), E(3'd4, 1, 1, 1, 1, 4'h2, 32'h400)});
    rows.push_back('{S(0, 32'h0, EV_NONE, 4'h0, 0, 0, 0),            E(3'd7, 0, 1, 1, 1, 4'h2, 32'h400)});
    foreach (rows[i]) begin
      @(posedge clk); #1;
      apply(rows[i].s);
      sb.push_back(rows[i].e);
      @(negedge clk);
      exp_v = sb.pop_front(); obs = sample(); checks++;
      if (obs !== exp_v) begin
        failures++; $display("FAIL mret_run[%0d] got %s want %s", i, fmt(obs), fmt(exp_v));
      end
    end
  endtask

  // Entered while the controller sits in TRAP_DRAIN.
  task automatic test_async_reset();
    row_t  rows[$];
    snap_t exp_v, obs;
    #2;
    rst_n = 1'b0;
    sb.push_back(E(3'd7, 0, 0, 0, 0, 4'h0, 32'h0));
    #1;
    exp_v = sb.pop_front(); obs = sample(); checks++;
    if (obs !== exp_v) begin
      failures++; $display("FAIL async_reset got %s want %s", fmt(obs), fmt(exp_v));
    end
    @(posedge clk); #1;
    rst_n = 1'b1;
    rows.push_back('{S(0, 32'h0, EV_NONE, 4'h0, 0, 0, 0),  E(3'd7, 0, 0, 0, 0, 4'h0, 32'h0)});
    rows.push_back('{S(1, 32'h600, EV_JAL, 4'h0, 0, 0, 0), E(3'd0, 1, 0, 0, 0, 4'h0, 32'h0)});
    foreach (rows[i]) begin
      if (i != 0) begin
        @(posedge clk); #1;
      end
      apply(rows[i].s);
      sb.push_back(rows[i].e);
      @(negedge clk);
      exp_v = sb.pop_front(); obs = sample(); checks++;
      if (obs !== exp_v) begin
        failures++; $display("FAIL after_reset[%0d] got %s want %s", i, fmt(obs), fmt(exp_v));
      end
    end
  endtask

  initial begin
    test_reset();
    test_redirect_priority();
    test_exception_entry();
    test_double_fault();
    test_return();
    test_irq_deferral();
    test_mret_in_run();
    test_async_reset();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
